// File: rtl/qam16_rx_pkg.sv
// ---------------------------------------------------------------------------
// qam16_rx_pkg
// Shared types and constants for the QAM16 receive-side demapper/framer.
//   state_t        : framer states (SEARCH, VERIFY, LOCKED)
//   L_*            : Gray-coded per-axis level codes produced by the slicer
//   DEF_SYNC_WORD  : default frame sync byte
//   DEF_FRAME_LEN  : default payload bytes between sync bytes
// ---------------------------------------------------------------------------
package qam16_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Gray order from most negative to most positive level
  localparam logic [1:0] L_NEG_OUT = 2'b00;
  localparam logic [1:0] L_NEG_IN  = 2'b01;
  localparam logic [1:0] L_POS_IN  = 2'b11;
  localparam logic [1:0] L_POS_OUT = 2'b10;

  localparam logic [7:0] DEF_SYNC_WORD = 8'h7E;
  localparam int         DEF_FRAME_LEN = 32;

endpackage

// File: rtl/qam16_slicer.sv
// ---------------------------------------------------------------------------
// qam16_slicer
// Registered hard-decision slicer: each signed I/Q sample pair is mapped to a
// 16QAM Gray symbol {I[1:0],Q[1:0]} one cycle after iq_valid.
// Ports:
//   clk        in   sample clock
//   rst_write  in   asynchronous active-high reset
//   iq_valid   in   sample strobe
//   i_data     in   signed in-phase sample  [DW-1:0]
//   q_data     in   signed quadrature sample [DW-1:0]
//   sym_out    out  sliced symbol (held between strobes)
//   sym_valid  out  single-cycle strobe for sym_out
// ---------------------------------------------------------------------------
module qam16_slicer
  import qam16_rx_pkg::*;
#(
  parameter int DW     = 14,
  parameter int THRESH = 1024
) (
  input  logic          clk,
  input  logic          rst_write,
  input  logic          iq_valid,
  input  logic [DW-1:0] i_data,
  input  logic [DW-1:0] q_data,
  output logic [3:0]    sym_out,
  output logic          sym_valid
);

  localparam logic signed [DW-1:0] THR_P = DW'(THRESH);
  localparam logic signed [DW-1:0] THR_N = -THR_P;

  logic [3:0] r_sym;
  logic       r_sym_valid;

  // Decision regions are closed on the upper side: +THRESH is outer,
  // -THRESH is inner, 0 is positive-inner.
  function automatic logic [1:0] slice_axis(input logic signed [DW-1:0] v);
    logic [1:0] lvl;
    if (v >= THR_P)
      lvl = L_POS_OUT;
    else if (v >= $signed({DW{1'b0}}))
      lvl = L_POS_IN;
    else if (v >= THR_N)
      lvl = L_NEG_IN;
    else
      lvl = L_NEG_OUT;
    return lvl;
  endfunction

  always_ff @(posedge clk or posedge rst_write) begin
    if (rst_write) begin
      r_sym       <= 4'd0;
      r_sym_valid <= 1'b0;
    end else begin
      r_sym_valid <= iq_valid;
      if (iq_valid)
        r_sym <= {slice_axis($signed(i_data)), slice_axis($signed(q_data))};
    end
  end

  assign sym_out   = r_sym;
  assign sym_valid = r_sym_valid;

endmodule

// File: rtl/qam16_demap_framer.sv
// ---------------------------------------------------------------------------
// qam16_demap_framer
// Slices recovered baseband I/Q to 16QAM nibbles, hunts for the sync byte in
// the nibble stream, confirms frame timing over LOCK_CNT sync slots and then
// emits payload bytes with a frame_start marker on the first byte of a frame.
// Ports:
//   clk          in   sample clock (50 MHz)
//   rst_write    in   asynchronous active-high reset
//   iq_valid     in   I/Q sample strobe
//   i_data       in   signed in-phase sample  [DW-1:0]
//   q_data       in   signed quadrature sample [DW-1:0]
//   sym_out      out  sliced symbol {I[1:0],Q[1:0]}
//   sym_valid    out  sym_out strobe
//   byte_data    out  payload byte
//   byte_valid   out  byte_data strobe (LOCKED only)
//   frame_start  out  coincides with the first payload byte of each frame
//   locked       out  frame lock indicator
//
// state  | meaning
// -------+---------------------------------------------------------------
// SEARCH | sliding 8-bit window over nibbles, waiting for SYNC_WORD
// VERIFY | byte-aligned, counting sync-slot hits until LOCK_CNT
// LOCKED | payload output; sync misses tolerated up to MISS_MAX-1 in a row
// ---------------------------------------------------------------------------
module qam16_demap_framer
  import qam16_rx_pkg::*;
#(
  parameter int         DW        = 14,
  parameter int         THRESH    = 1024,
  parameter logic [7:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter int         FRAME_LEN = DEF_FRAME_LEN,
  parameter int         LOCK_CNT  = 3,
  parameter int         MISS_MAX  = 2
) (
  input  logic          clk,
  input  logic          rst_write,
  input  logic          iq_valid,
  input  logic [DW-1:0] i_data,
  input  logic [DW-1:0] q_data,
  output logic [3:0]    sym_out,
  output logic          sym_valid,
  output logic [7:0]    byte_data,
  output logic          byte_valid,
  output logic          frame_start,
  output logic          locked
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_MAX + 1);

  localparam logic [CW-1:0] SLOT_IDX = CW'(FRAME_LEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [HW-1:0] HIT_ONE  = HW'(1);
  localparam logic [HW-1:0] HIT_LOCK = HW'(LOCK_CNT);
  localparam logic [MW-1:0] MISS_ONE = MW'(1);
  localparam logic [MW-1:0] MISS_LIM = MW'(MISS_MAX);

  logic [3:0]    w_sym;
  logic          w_sym_valid;
  logic [7:0]    w_sr_next;
  logic          w_sync_hit;
  logic          w_slot;

  state_t        r_state;
  logic [7:0]    r_sr8;
  logic          r_phase;
  logic [CW-1:0] r_byte_cnt;
  logic [HW-1:0] r_hit;
  logic [MW-1:0] r_miss;
  logic [7:0]    r_byte_data;
  logic          r_byte_valid;
  logic          r_frame_start;
  logic          r_locked;

  qam16_slicer #(
    .DW     (DW),
    .THRESH (THRESH)
  ) u_slicer (
    .clk       (clk),
    .rst_write (rst_write),
    .iq_valid  (iq_valid),
    .i_data    (i_data),
    .q_data    (q_data),
    .sym_out   (w_sym),
    .sym_valid (w_sym_valid)
  );

  // The shift register runs in every state, so on a phase-1 symbol the
  // updated window is exactly the completed byte.
  assign w_sr_next  = {r_sr8[3:0], w_sym};
  assign w_sync_hit = (w_sr_next == SYNC_WORD);
  assign w_slot     = (r_byte_cnt == SLOT_IDX);

  always_ff @(posedge clk or posedge rst_write) begin
    if (rst_write) begin
      r_state       <= SEARCH;
      r_sr8         <= 8'd0;
      r_phase       <= 1'b0;
      r_byte_cnt    <= '0;
      r_hit         <= '0;
      r_miss        <= '0;
      r_byte_data   <= 8'd0;
      r_byte_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_byte_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      if (w_sym_valid) begin
        r_sr8 <= w_sr_next;
        case (r_state)
          SEARCH: begin
            if (w_sync_hit) begin
              r_state    <= VERIFY;
              r_hit      <= HIT_ONE;
              r_byte_cnt <= '0;
              r_phase    <= 1'b0;
            end
          end

          VERIFY: begin
            r_phase <= ~r_phase;
            if (r_phase) begin
              if (!w_slot) begin
                r_byte_cnt <= r_byte_cnt + CNT_ONE;
              end else begin
                r_byte_cnt <= '0;
                if (w_sync_hit) begin
                  r_hit <= r_hit + HIT_ONE;
                  if (r_hit + HIT_ONE == HIT_LOCK) begin
                    r_state  <= LOCKED;
                    r_locked <= 1'b1;
                    r_miss   <= '0;
                  end
                end else begin
                  // Window keeps this byte; the hunt resumes from here.
                  r_state <= SEARCH;
                  r_hit   <= '0;
                end
              end
            end
          end

          LOCKED: begin
            r_phase <= ~r_phase;
            if (r_phase) begin
              if (!w_slot) begin
                r_byte_data   <= w_sr_next;
                r_byte_valid  <= 1'b1;
                r_frame_start <= (r_byte_cnt == '0);
                r_byte_cnt    <= r_byte_cnt + CNT_ONE;
              end else begin
                // Frame timing is kept across a bad sync (flywheel).
                r_byte_cnt <= '0;
                if (w_sync_hit) begin
                  r_miss <= '0;
                end else if (r_miss + MISS_ONE == MISS_LIM) begin
                  r_state  <= SEARCH;
                  r_locked <= 1'b0;
                  r_hit    <= '0;
                  r_miss   <= '0;
                end else begin
                  r_miss <= r_miss + MISS_ONE;
                end
              end
            end
          end

          default: r_state <= SEARCH;
        endcase
      end
    end
  end

  assign sym_out     = w_sym;
  assign sym_valid   = w_sym_valid;
  assign byte_data   = r_byte_data;
  assign byte_valid  = r_byte_valid;
  assign frame_start = r_frame_start;
  assign locked      = r_locked;

endmodule

// File: doc/qam16_demap_framer.md
Name: qam16_demap_framer

Overview:
- Downstream consumer of the QAM16 receive datapath's recovered baseband I/Q samples (the 14-bit signed pair also driven to DA/DB).
- Slices each I/Q pair to a 16QAM Gray symbol, searches the nibble stream for a sync byte, and verifies frame timing.
- Once locked, outputs payload bytes with frame-start marking.
- Used on the board and in simulation to turn demodulated I/Q into checkable byte data.

Parameters:
- DW, 14, I/Q sample width (signed).
- THRESH, 1024, outer/inner decision threshold magnitude per axis.
- SYNC_WORD, 8'h7E, frame sync byte.
- FRAME_LEN, 32, payload bytes between sync bytes.
- LOCK_CNT, 3, consecutive sync matches (including the first) needed to lock.
- MISS_MAX, 2, consecutive sync misses that drop lock.

Ports:
- clk  in  1  sample clock (50 MHz).
- rst_write  in  1  reset: asynchronous, active-high.
- iq_valid  in  1  I/Q sample strobe.
- i_data  in  DW  signed in-phase sample.
- q_data  in  DW  signed quadrature sample.
- sym_out  out  4  sliced symbol {I[1:0],Q[1:0]}.
- sym_valid  out  1  sym_out strobe.
- byte_data  out  8  payload byte.
- byte_valid  out  1  byte_data strobe (LOCKED only).
- frame_start  out  1  pulse coincident with the first payload byte of each frame.
- locked  out  1  frame lock indicator.

Behaviour:
- Reset:
  - All outputs are 0.
  - State is SEARCH; shift register, counters and nibble phase are cleared.
  - rst_write asserted mid-frame clears everything immediately (asynchronous); reacquisition requires LOCK_CNT syncs.
- Slicer (per axis, signed compare):
  - v >= THRESH -> 2'b10.
  - 0 <= v < THRESH -> 2'b11.
  - -THRESH <= v < 0 -> 2'b01.
  - v < -THRESH -> 2'b00.
  - Registered: sym_valid/sym_out appear 1 cycle after iq_valid.
  - No iq_valid means no sym_valid and all state held. Gaps of any length are allowed.
- SEARCH:
  - On each sym_valid, sr8 <= {sr8[3:0], sym}. The check uses the updated value.
  - If sr8 == SYNC_WORD: go to VERIFY, hit=1, byte_cnt=0, nibble phase=0.
- Byte assembly (VERIFY/LOCKED):
  - Phase 0 symbol becomes the high nibble; phase 1 symbol completes the byte.
  - The completed byte is registered 1 cycle after the phase-1 sym_valid, i.e. 2 cycles after its iq_valid.
  - byte_cnt 0..FRAME_LEN-1 counts payload bytes. The byte after FRAME_LEN payload bytes is the sync slot.
- VERIFY:
  - Sync slot == SYNC_WORD: hit++. If hit reaches LOCK_CNT, go to LOCKED with locked=1 asserted in the same cycle the byte completes.
  - Sync slot mismatch: go to SEARCH, hit=0. The shift register restarts from the current byte.
  - No byte_valid is produced in VERIFY.
- LOCKED:
  - Payload bytes pulse byte_valid. frame_start accompanies byte_cnt==0.
  - Sync slot match: miss=0.
  - Sync slot mismatch: miss++, frame timing kept (flywheel), next frame still output.
  - miss reaching MISS_MAX: go to SEARCH, locked=0 on that cycle, no further byte_valid.
  - The sync byte itself is never output.
- Simultaneous events: a sync match and lock transition on the same byte produce one locked rise. frame_start and byte_valid always coincide.
- byte_valid/frame_start/sym_valid are single-cycle pulses.

Decomposition:
- Package qam16_rx_pkg:
  - State enum {SEARCH, VERIFY, LOCKED}.
  - Gray level codes (L_NEG_OUT=00, L_NEG_IN=01, L_POS_IN=11, L_POS_OUT=10).
  - Default SYNC_WORD and FRAME_LEN.
- One sub-module, qam16_slicer: registered per-axis compare and Gray map, outputting sym_out/sym_valid.
- The framer FSM, packer and counters live in the top.

Test Plan:
- Slicer:
  - I=3000, Q=-3000 -> sym 4'b1000.
  - I=0, Q=-1 -> 4'b1101.
  - I=1024, Q=-1024 -> 4'b1001.
  - I=-1025, Q=1023 -> 4'b0011.
  - Each appears exactly 1 cycle after iq_valid.
- Acquisition:
  - Input: 20 random symbols, then 4 frames of [0x7E + 32 bytes 0x00..0x1F]. The 0x7E nibbles are (I=-500,Q=500) then (I=500,Q=3000).
  - locked rises at the 3rd sync.
  - Frames 3 and 4 output 0x00..0x1F with frame_start on 0x00.
- Flywheel: while locked, corrupt one sync byte to 0x7F -> locked stays 1 and the next 32 bytes are output. Corrupt two consecutive syncs -> locked falls at the 2nd bad sync and byte_valid stops.
- Verify fail: sync + 32 bytes + 0x00 in the sync slot -> return to SEARCH, no byte_valid ever, locked=0.
- Reset mid-frame: pulse rst_write at byte 10 of a locked frame -> all outputs 0 immediately. Relock only after 3 further valid syncs.
- Throttling: iq_valid asserted every 3rd cycle with the acquisition stream -> identical byte sequence and lock point (in symbols).
